// File: rtl/cycle_ctrl.sv
// ---------------------------------------------------------------------------
// cycle_ctrl -- CPU run/step/halt sequencer with enabled-cycle counter.
//
// Gates the CPU clock enable from a small FSM (IDLE/RUN/STEP/HALTED/TIMEOUT).
// It counts every cycle in which the CPU is enabled, and the count saturates
// at all-ones. An optional watchdog moves RUN/STEP to TIMEOUT once
// MAX_CYCLES enabled cycles have elapsed.
//
// Build option:
//   CYCLE_CTRL_WATCHDOG_EN  defined   -> watchdog active, TIMEOUT reachable
//                           undefined -> no watchdog, timeout tied to 0
//
// Parameters:
//   CNT_W       width of cycle_count
//   MAX_CYCLES  watchdog limit in enabled cycles (unused without watchdog)
//
// Ports:
//   clk          free-running clock, rising edge
//   reset        asynchronous active-high reset
//   run_req      level request for continuous execution
//   step_req     single-step request, acted on at its rising edge
//   halt_in      CPU halt indication, observed only while cpu_en=1
//   clr          clears HALTED/TIMEOUT back to IDLE and zeroes the counter
//   cpu_en       CPU clock enable (RUN or STEP)
//   state        IDLE=0 RUN=1 STEP=2 HALTED=3 TIMEOUT=4
//   cycle_count  number of enabled cycles
//   halted       state==HALTED
//   timeout      state==TIMEOUT
// ---------------------------------------------------------------------------
module cycle_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_in,
    input  logic             clr,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted,
    output logic             timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_STEP    = 3'd2,
        S_HALTED  = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en;
    logic               step_edge;
    logic               wd_hit;

    // Outputs decode the state register only; no input reaches them.
    assign en          = (state_q == S_RUN) || (state_q == S_STEP);
    assign cpu_en      = en;
    assign state       = state_q;
    assign cycle_count = cnt_q;
    assign halted      = (state_q == S_HALTED);
    assign timeout     = (state_q == S_TIMEOUT);

    // The previous sample is updated every cycle, so an edge seen outside
    // IDLE is consumed and cannot fire later.
    assign step_edge = step_req && !step_q;

`ifdef CYCLE_CTRL_WATCHDOG_EN
    // Compare at 64 bits so a narrow counter never aliases onto the limit.
    assign wd_hit = en && (64'(cnt_q) == (64'(MAX_CYCLES) - 64'd1));
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_req;
        cnt_d   = cnt_q;

        if (en && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (run_req)        state_d = S_RUN;
                else if (step_edge) state_d = S_STEP;
            end
            S_RUN: begin
                if (halt_in)       state_d = S_HALTED;
                else if (wd_hit)   state_d = S_TIMEOUT;
                else if (!run_req) state_d = S_IDLE;
            end
            S_STEP: begin
                if (halt_in)     state_d = S_HALTED;
                else if (wd_hit) state_d = S_TIMEOUT;
                else             state_d = S_IDLE;
            end
            S_HALTED, S_TIMEOUT: begin
                if (clr) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
